// File: rtl/host_mem_sequencer.sv
// Host-side sequencer: streams operands into data memory, pulses START, waits for END,
// then reads the result region back out as a word stream.
module host_mem_sequencer #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int READ_LAT = 1,
    parameter int TIMEOUT  = 65535
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              go,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [15:0]       load_len,
    input  logic [ADDR_W-1:0] res_base,
    input  logic [15:0]       res_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        addr_mux_select,
    output logic [ADDR_W-1:0] current_addr,
    output logic              write_from_tb,
    output logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] ar_in,
    output logic              START,
    input  logic              END,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, LOAD, LOAD_LAST, START_P, RUN_WAIT, READ_ADDR, READ_WAIT, READ_OUT, DONE
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] lbase_q, rbase_q;
    logic [15:0]       llen_q, rlen_q;
    logic [15:0]       k_q, k_nx, m_q, m_nx;
    logic [CNT_W-1:0]  cnt_q, cnt_nx;
    logic [2:0]        lat_q, lat_nx;

    logic              in_ready_nx, out_valid_nx, write_nx, start_nx, busy_nx, done_nx, err_nx;
    logic [1:0]        mux_nx;
    logic [ADDR_W-1:0] cur_addr_nx, ar_in_nx;
    logic [DATA_W-1:0] mem_data_nx, out_data_nx;

    // Every output is computed one cycle ahead here and registered below.
    always_comb begin
        state_nx     = state;
        k_nx         = k_q;
        m_nx         = m_q;
        cnt_nx       = cnt_q;
        lat_nx       = lat_q;
        in_ready_nx  = in_ready;
        mux_nx       = addr_mux_select;
        cur_addr_nx  = current_addr;
        mem_data_nx  = mem_data;
        ar_in_nx     = ar_in;
        out_valid_nx = out_valid;
        out_data_nx  = out_data;
        err_nx       = err;
        write_nx     = 1'b0;
        start_nx     = 1'b0;
        done_nx      = 1'b0;

        case (state)
            IDLE: begin
                if (go) begin
                    err_nx = 1'b0;
                    k_nx   = '0;
                    if (load_len == 16'd0) begin
                        state_nx = START_P;
                        start_nx = 1'b1;
                        mux_nx   = 2'b00;
                    end else begin
                        state_nx    = LOAD;
                        in_ready_nx = 1'b1;
                        mux_nx      = 2'b01;
                    end
                end
            end
            LOAD: begin
                if (in_valid && in_ready) begin
                    write_nx    = 1'b1;
                    cur_addr_nx = lbase_q + ADDR_W'(k_q);
                    mem_data_nx = in_data;
                    k_nx        = k_q + 16'd1;
                    if (k_q + 16'd1 == llen_q) begin
                        in_ready_nx = 1'b0;
                        state_nx    = LOAD_LAST;
                    end
                end
            end
            // The final write is on the bus during this cycle, so the mux stays on tb-write.
            LOAD_LAST: begin
                state_nx = START_P;
                start_nx = 1'b1;
                mux_nx   = 2'b00;
            end
            START_P: begin
                state_nx = RUN_WAIT;
                cnt_nx   = '0;
            end
            RUN_WAIT: begin
                if (END) begin
                    m_nx = '0;
                    if (rlen_q == 16'd0) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = READ_ADDR;
                        mux_nx   = 2'b10;
                        ar_in_nx = rbase_q;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_nx   = 1'b1;
                    state_nx = DONE;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end
            READ_ADDR: begin
                state_nx = READ_WAIT;
                lat_nx   = 3'd1;
            end
            READ_WAIT: begin
                if (lat_q == 3'(READ_LAT)) begin
                    out_data_nx  = dmem_rdata;
                    out_valid_nx = 1'b1;
                    state_nx     = READ_OUT;
                end else begin
                    lat_nx = lat_q + 3'd1;
                end
            end
            READ_OUT: begin
                if (out_ready) begin
                    out_valid_nx = 1'b0;
                    m_nx         = m_q + 16'd1;
                    if (m_q + 16'd1 == rlen_q) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                        mux_nx   = 2'b00;
                    end else begin
                        state_nx = READ_ADDR;
                        ar_in_nx = rbase_q + ADDR_W'(m_q + 16'd1);
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                mux_nx   = 2'b00;
            end
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state           <= IDLE;
            k_q             <= '0;
            m_q             <= '0;
            cnt_q           <= '0;
            lat_q           <= '0;
            in_ready        <= 1'b0;
            addr_mux_select <= 2'b00;
            current_addr    <= '0;
            mem_data        <= '0;
            write_from_tb   <= 1'b0;
            ar_in           <= '0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            START           <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            state           <= state_nx;
            k_q             <= k_nx;
            m_q             <= m_nx;
            cnt_q           <= cnt_nx;
            lat_q           <= lat_nx;
            in_ready        <= in_ready_nx;
            addr_mux_select <= mux_nx;
            current_addr    <= cur_addr_nx;
            mem_data        <= mem_data_nx;
            write_from_tb   <= write_nx;
            ar_in           <= ar_in_nx;
            out_valid       <= out_valid_nx;
            out_data        <= out_data_nx;
            START           <= start_nx;
            busy            <= busy_nx;
            done            <= done_nx;
            err             <= err_nx;
        end
    end

    // Sequence parameters are frozen for the whole run once go is accepted.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            lbase_q <= '0;
            llen_q  <= '0;
            rbase_q <= '0;
            rlen_q  <= '0;
        end else if (state == IDLE && go) begin
            lbase_q <= load_base;
            llen_q  <= load_len;
            rbase_q <= res_base;
            rlen_q  <= res_len;
        end
    end

endmodule

// File: tb/tb_host_mem_sequencer.sv
// Self-checking bench for host_mem_sequencer: scoreboarded writes/reads against a
// behavioural data memory with a two-cycle read latency.
module tb_host_mem_sequencer;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int TB_READ_LAT = 2;
    localparam int TB_TIMEOUT  = 50;

    logic              clk = 1'b0;
    logic              RESET;
    logic              go;
    logic [ADDR_W-1:0] load_base, res_base;
    logic [15:0]       load_len, res_len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [1:0]        addr_mux_select;
    logic [ADDR_W-1:0] current_addr;
    logic              write_from_tb;
    logic [DATA_W-1:0] mem_data;
    logic [ADDR_W-1:0] ar_in;
    logic              START;
    logic              END;
    logic [DATA_W-1:0] dmem_rdata;
    logic              busy, done, err;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } wr_exp_t;

    wr_exp_t     wr_q[$];
    logic [15:0] rd_q[$];
    logic [15:0] words [8];
    logic [15:0] mem [0:65535];
    logic [15:0] rd_pipe0, rd_pipe1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_count = 0;
    int start_count = 0;
    int mux10_count = 0;
    int ov_count = 0;
    int exp_starts = 0;
    logic        prev_ov = 1'b0;
    logic        prev_hs = 1'b0;
    logic [15:0] prev_od = '0;

    always #5 clk = ~clk;

    host_mem_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(TB_READ_LAT), .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk(clk), .RESET(RESET), .go(go),
        .load_base(load_base), .load_len(load_len), .res_base(res_base), .res_len(res_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .addr_mux_select(addr_mux_select), .current_addr(current_addr),
        .write_from_tb(write_from_tb), .mem_data(mem_data), .ar_in(ar_in),
        .START(START), .END(END), .dmem_rdata(dmem_rdata),
        .busy(busy), .done(done), .err(err)
    );

    // Behavioural data memory seen through the top-level address mux.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (write_from_tb && addr_mux_select == 2'b01)
            mem[current_addr] <= mem_data;
        rd_pipe0 <= (addr_mux_select == 2'b10) ? mem[ar_in] : 16'hxxxx;
        rd_pipe1 <= rd_pipe0;
    end
    assign dmem_rdata = rd_pipe1;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops the scoreboards and checks output hold behaviour between edges.
    always @(negedge clk) begin
        if (write_from_tb) begin
            wr_count <= wr_count + 1;
            check_output("wr_mux", 32'(addr_mux_select), 32'h1);
            if (wr_q.size() == 0) begin
                check_output("wr_unexpected", 32'(write_from_tb), 32'h0);
            end else begin
                check_output("wr_addr", 32'(current_addr), 32'(wr_q[0].addr));
                check_output("wr_data", 32'(mem_data), 32'(wr_q[0].data));
                check_output("wr_cycle", cyc, wr_q[0].cyc);
                void'(wr_q.pop_front());
            end
        end
        if (START) start_count <= start_count + 1;
        if (addr_mux_select == 2'b10) mux10_count <= mux10_count + 1;
        if (out_valid) ov_count <= ov_count + 1;
        if (prev_ov && !prev_hs) begin
            check_output("ov_hold", 32'(out_valid), 32'h1);
            check_output("od_hold", 32'(out_data), 32'(prev_od));
        end
        if (out_valid && out_ready) begin
            if (rd_q.size() == 0) begin
                check_output("rd_unexpected", 32'(out_valid), 32'h0);
            end else begin
                check_output("rd_data", 32'(out_data), 32'(rd_q[0]));
                void'(rd_q.pop_front());
            end
        end
        prev_ov <= out_valid;
        prev_hs <= out_valid && out_ready;
        prev_od <= out_data;
    end

    function automatic logic flag_val(input int which);
        case (which)
            0:       return START;
            1:       return out_valid;
            default: return done;
        endcase
    endfunction

    task automatic wait_flag(input int which, input int limit, input string tag);
        int n = 0;
        while (!flag_val(which) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check_output(tag, 32'(flag_val(which)), 32'h1);
    endtask

    task automatic start_seq(input logic [15:0] lb, input logic [15:0] ll,
                             input logic [15:0] rb, input logic [15:0] rl);
        load_base = lb; load_len = ll; res_base = rb; res_len = rl;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [15:0] base, input int n, input bit gap, input bit last);
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = words[i];
            check_output("in_ready_hi", 32'(in_ready), 32'h1);
            wr_q.push_back('{addr: base + 16'(i), data: words[i], cyc: cyc + 1});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (last) check_output("in_ready_drop", 32'(in_ready), 32'h0);
    endtask

    task automatic run_to_done(input string tag);
        wait_flag(0, 10, {tag, "_start"});
        exp_starts++;
        @(posedge clk); #1;
        check_output({tag, "_start_width"}, 32'(START), 32'h0);
        END = 1'b1;
        @(posedge clk); #1;
        END = 1'b0;
        check_output({tag, "_done"}, 32'(done), 32'h1);
        @(posedge clk); #1;
        check_output({tag, "_idle"}, 32'({busy, done}), 32'h0);
        check_output({tag, "_starts"}, start_count, exp_starts);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int snap_a, snap_b;
        RESET = 1'b0; go = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; END = 1'b0;
        load_base = '0; load_len = '0; res_base = '0; res_len = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_ctrl", 32'({write_from_tb, in_ready, START, done, busy, out_valid, err, addr_mux_select}), 32'h0);
        check_output("rst_addr", {current_addr, ar_in}, 32'h0);
        check_output("rst_data", {out_data, mem_data}, 32'h0);
        RESET = 1'b1;
        @(posedge clk); #1;

        $display("[TB] 4-word load, in_valid held high");
        words[0] = 16'h0001; words[1] = 16'h0002; words[2] = 16'h0003; words[3] = 16'h0004;
        start_seq(16'h0010, 16'd4, 16'h0000, 16'd0);
        check_output("busy_load", 32'(busy), 32'h1);
        apply_stimulus(16'h0010, 4, 1'b0, 1'b1);
        run_to_done("load4");
        check_output("mem_0013", 32'(mem[16'h0013]), 32'h4);

        $display("[TB] 3-word load, in_valid toggling");
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
        snap_a = wr_count;
        start_seq(16'h0020, 16'd3, 16'h0000, 16'd0);
        apply_stimulus(16'h0020, 3, 1'b1, 1'b1);
        run_to_done("gap3");
        check_output("gap3_writes", wr_count - snap_a, 32'd3);

        $display("[TB] readback with out_ready stall");
        words[0] = 16'hBEEF; words[1] = 16'hCAFE;
        out_ready = 1'b0;
        start_seq(16'h0100, 16'd2, 16'h0100, 16'd2);
        apply_stimulus(16'h0100, 2, 1'b0, 1'b1);
        rd_q.push_back(16'hBEEF);
        rd_q.push_back(16'hCAFE);
        wait_flag(0, 10, "rd_start");
        exp_starts++;
        repeat (20) begin @(posedge clk); #1; end
        END = 1'b1;
        @(posedge clk); #1;
        END = 1'b0;
        wait_flag(1, 20, "rd_ov_first");
        check_output("rd_first", 32'(out_data), 32'hBEEF);
        repeat (5) begin @(posedge clk); #1; end
        check_output("rd_stall", 32'({out_valid, out_data}), 32'h1BEEF);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_output("rd_drop", 32'(out_valid), 32'h0);
        wait_flag(1, 20, "rd_ov_second");
        check_output("rd_second", 32'(out_data), 32'hCAFE);
        wait_flag(2, 10, "rd_done");
        @(posedge clk); #1;
        check_output("rd_idle", 32'(busy), 32'h0);
        check_output("rd_drained", rd_q.size(), 32'd0);

        $display("[TB] timeout with END never asserted");
        snap_a = mux10_count;
        start_seq(16'h0000, 16'd0, 16'h0100, 16'd1);
        check_output("to_start", 32'(START), 32'h1);
        exp_starts++;
        repeat (TB_TIMEOUT) begin @(posedge clk); #1; end
        check_output("to_pre", 32'({err, done}), 32'h0);
        @(posedge clk); #1;
        check_output("to_err", 32'({err, done}), 32'h3);
        @(posedge clk); #1;
        check_output("to_sticky", 32'({busy, err}), 32'h1);
        check_output("to_no_read", mux10_count, snap_a);

        $display("[TB] zero-length load and readback");
        snap_a = wr_count;
        snap_b = ov_count;
        start_seq(16'h0000, 16'd0, 16'h0000, 16'd0);
        check_output("zero_err_clr", 32'({err, START}), 32'h1);
        run_to_done("zero");
        check_output("zero_no_write", wr_count, snap_a);
        check_output("zero_no_ov", ov_count, snap_b);

        $display("[TB] address wrap");
        words[0] = 16'h7001; words[1] = 16'h7002; words[2] = 16'h7003;
        start_seq(16'hFFFE, 16'd3, 16'h0000, 16'd0);
        apply_stimulus(16'hFFFE, 3, 1'b0, 1'b1);
        run_to_done("wrap");
        check_output("wrap_mem0", 32'(mem[16'h0000]), 32'h7003);

        $display("[TB] reset mid-load");
        words[0] = 16'h5A01; words[1] = 16'h5A02;
        start_seq(16'h0040, 16'd4, 16'h0000, 16'd0);
        apply_stimulus(16'h0040, 2, 1'b0, 1'b0);
        @(negedge clk); #1;
        RESET = 1'b0;
        #1;
        check_output("arst_ctrl", 32'({write_from_tb, in_ready, START, done, busy, out_valid, err, addr_mux_select}), 32'h0);
        check_output("arst_addr", {current_addr, ar_in}, 32'h0);
        snap_a = wr_count;
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        repeat (3) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        RESET = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        check_output("arst_no_start", start_count, exp_starts);
        check_output("arst_idle", 32'({busy, in_ready}), 32'h0);
        check_output("arst_no_write", wr_count, snap_a);
        check_output("wr_pending", wr_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
